mmio_store_sink: RTL and testbench

Memory-side responder for the core's store port. It consumes the `mem_addr`/`mem_data`/`mem_we` bus the core drives every cycle, with no stall path back to the core. Stores are decoded into a word-addressed data RAM, an LED register, a control register, and a byte FIFO that feeds an 8N1 serial transmitter. A synchronous debug read port exposes RAM contents to the bench and the board.

---
 rtl/mmio_store_sink.sv | 155 +++++++++++++++
 tb/tb_mmio_store_sink.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_store_sink.sv
// Store-port responder for the core: decodes stores into a data RAM, an LED register,
// a control register and a byte FIFO that feeds an 8N1 serial transmitter.
//
// state | meaning
// IDLE  | line high; pops a byte when the FIFO holds one
// START | start bit (low) for CLK_DIV cycles
// DATA  | 8 data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high) for CLK_DIV cycles
module mmio_store_sink #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_data,
    input  logic                          mem_we,
    input  logic [$clog2(RAM_WORDS)-1:0]  dbg_raddr,
    output logic [31:0]                   dbg_rdata,
    output logic [15:0]                   leds,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          bad_addr
);

    localparam int RAW = $clog2(RAM_WORDS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int TW  = $clog2(CLK_DIV);

    localparam logic [31:0] ADDR_LED  = 32'h8000_0000;
    localparam logic [31:0] ADDR_TX   = 32'h8000_0001;
    localparam logic [31:0] ADDR_CTRL = 32'h8000_0002;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t state, next_state;

    logic          ram_sel, led_sel, tx_sel, ctrl_sel;
    logic          ram_wr, led_wr, push_req, ctrl_wr, unmapped;
    logic [31:0]   ram [RAM_WORDS];

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, push, pop, drop;

    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    always_comb begin
        ram_sel  = mem_addr < 32'(RAM_WORDS);
        led_sel  = mem_addr == ADDR_LED;
        tx_sel   = mem_addr == ADDR_TX;
        ctrl_sel = mem_addr == ADDR_CTRL;
        ram_wr   = mem_we && ram_sel;
        led_wr   = mem_we && led_sel;
        push_req = mem_we && tx_sel;
        ctrl_wr  = mem_we && ctrl_sel;
        unmapped = mem_we && !(ram_sel || led_sel || tx_sel || ctrl_sel);
    end

    always_ff @(posedge clk) begin
        if (ram_wr) ram[mem_addr[RAW-1:0]] <= mem_data;
    end

    // Read-first: the non-blocking RAM write lands after this read samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_rdata <= '0;
        else        dbg_rdata <= ram[dbg_raddr];
    end

    always_comb begin
        fifo_full  = count == CW'(FIFO_DEPTH);
        fifo_empty = count == '0;
        pop        = (state == IDLE) && !fifo_empty;
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            leds     <= '0;
            overflow <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (led_wr) leds <= mem_data[15:0];
            // a set in the same cycle overrides the clear
            overflow <= drop     | (overflow & ~(ctrl_wr & mem_data[0]));
            bad_addr <= unmapped | (bad_addr & ~(ctrl_wr & mem_data[1]));
        end
    end

    assign bit_end = timer == TW'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!fifo_empty) next_state = START;
            START: if (bit_end) next_state = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) next_state = STOP;
            STOP:  if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            if (state == IDLE || bit_end) timer <= '0;
            else                          timer <= timer + TW'(1);
            if (pop) begin
                shreg   <= fifo_mem[rd_ptr];
                bit_idx <= '0;
            end else if (state == DATA && bit_end) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[0];
                default: tx <= 1'b1;
            endcase
        end
    end

    assign tx_busy    = (state != IDLE) || !fifo_empty;
    assign fifo_count = count;

endmodule

// File: tb/tb_mmio_store_sink.sv
// Bench for mmio_store_sink: a frame-position/queue model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mmio_store_sink;

    localparam int RW = 256;
    localparam int DEPTH = 8;
    localparam int CD = 4;

    localparam logic [31:0] A_LED  = 32'h8000_0000;
    localparam logic [31:0] A_TX   = 32'h8000_0001;
    localparam logic [31:0] A_CTRL = 32'h8000_0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        mem_we = 1'b0;
    logic [7:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;
    logic [15:0] leds;
    logic        tx, tx_busy, overflow, bad_addr;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    mmio_store_sink #(.RAM_WORDS(RW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .leds(leds), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
        .overflow(overflow), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus "frame age" (edges since the pop) of the byte on the wire.
    logic [15:0] m_leds = '0;
    logic        m_ovf = 1'b0, m_bad = 1'b0, m_tx = 1'b1, m_active = 1'b0;
    int          m_age = 0;
    logic [7:0]  m_byte = '0;
    logic [7:0]  q[$];
    logic [31:0] m_ram [RW];
    bit          m_ram_ok [RW];
    logic [31:0] m_dbg = '0;
    bit          m_dbg_ok = 1'b1;

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit do_pop;
        if (!rst_n) begin
            m_leds = '0; m_ovf = 0; m_bad = 0; m_tx = 1; m_active = 0; m_age = 0;
            m_dbg = '0; m_dbg_ok = 1;
            q.delete();
        end else begin
            m_dbg_ok = m_ram_ok[dbg_raddr];
            m_dbg    = m_ram[dbg_raddr];
            m_tx     = m_active ? frame_bit(m_byte, m_age / CD) : 1'b1;
            do_pop   = !m_active && q.size() > 0;
            if (m_active) begin
                m_age++;
                if (m_age == 10 * CD) m_active = 0;
            end
            if (do_pop) begin
                m_byte = q.pop_front();
                m_active = 1; m_age = 0;
            end
            if (mem_we) begin
                if (mem_addr < RW) begin
                    m_ram[mem_addr[7:0]] = mem_data;
                    m_ram_ok[mem_addr[7:0]] = 1;
                end else if (mem_addr == A_LED) m_leds = mem_data[15:0];
                else if (mem_addr == A_TX) begin
                    if (q.size() == DEPTH) m_ovf = 1;
                    else q.push_back(mem_data[7:0]);
                end else if (mem_addr == A_CTRL) begin
                    if (mem_data[0]) m_ovf = 0;
                    if (mem_data[1]) m_bad = 0;
                end else m_bad = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("leds", 32'(leds), 32'(m_leds));
        check("tx", 32'(tx), 32'(m_tx));
        check("tx_busy", 32'(tx_busy), 32'(m_active || q.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("bad_addr", 32'(bad_addr), 32'(m_bad));
        if (m_dbg_ok) check("dbg_rdata", dbg_rdata, m_dbg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1; mem_addr = a; mem_data = d;
        tick();
        mem_we = 0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (tx_busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(tx_busy), 32'(0));
    endtask

    // Called right after the push edge N; th[k] is tx after edge N+k.
    task automatic capture(input string tag, input logic [0:7] bits);
        logic th [0:47];
        logic bh [0:47];
        th[0] = tx; bh[0] = tx_busy;
        for (int k = 1; k <= 45; k++) begin
            tick();
            th[k] = tx; bh[k] = tx_busy;
        end
        check({tag, "_pre"}, 32'(th[1]), 32'(1));
        check({tag, "_start0"}, 32'(th[2]), 32'(0));
        check({tag, "_start3"}, 32'(th[5]), 32'(0));
        for (int i = 0; i < 8; i++) check({tag, "_bit"}, 32'(th[4*i+8]), 32'(bits[i]));
        check({tag, "_stop"}, 32'(th[40]), 32'(1));
        check({tag, "_after"}, 32'(th[42]), 32'(1));
        check({tag, "_busy_last"}, 32'(bh[40]), 32'(1));
        check({tag, "_busy_fall"}, 32'(bh[41]), 32'(0));
    endtask

    initial begin
        rst_n = 0;
        tick(); tick();
        mem_we = 1; mem_addr = A_LED; mem_data = 32'hFFFF;
        tick(); tick();
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_count", 32'(fifo_count), 32'h0);
        check("rst_flags", {30'b0, overflow, bad_addr}, 32'h0);
        check("rst_dbg", dbg_rdata, 32'h0);
        mem_we = 0;
        rst_n = 1;
        tick();
        store(A_LED, 32'hFFFF);
        check("leds_write", 32'(leds), 32'hFFFF);

        store(32'd5, 32'hDEADBEEF);
        dbg_raddr = 8'd5;
        tick();
        check("ram_read", dbg_rdata, 32'hDEADBEEF);
        store(32'd5, 32'h1);
        check("ram_read_first", dbg_rdata, 32'hDEADBEEF);
        tick();
        check("ram_new", dbg_rdata, 32'h1);

        store(32'd255, 32'hCAFE0001);
        check("ram_top_ok", 32'(bad_addr), 32'h0);
        store(32'd256, 32'h77);
        check("ram_past_top", 32'(bad_addr), 32'h1);
        dbg_raddr = 8'd255;
        tick();
        check("ram_top", dbg_rdata, 32'hCAFE0001);
        store(A_CTRL, 32'h2);
        check("bad_clr", 32'(bad_addr), 32'h0);

        store(A_TX, 32'hA5);
        check("push_count", 32'(fifo_count), 32'h1);
        capture("a5", 8'b1010_0101);

        wait_idle(200);
        for (int i = 0; i < 10; i++) store(A_TX, 32'h10 + i);
        check("ovf_count", 32'(fifo_count), 32'h8);
        check("ovf_set", 32'(overflow), 32'h1);
        store(A_CTRL, 32'h1);
        check("ovf_clr", 32'(overflow), 32'h0);
        wait_idle(1000);

        store(32'h4000_0000, 32'h1234_5678);
        check("bad_set", 32'(bad_addr), 32'h1);
        check("bad_leds", 32'(leds), 32'hFFFF);
        check("bad_fifo", 32'(fifo_count), 32'h0);
        dbg_raddr = 8'd5;
        tick();
        check("bad_ram", dbg_rdata, 32'h1);
        store(A_CTRL, 32'h0);
        check("bad_hold", 32'(bad_addr), 32'h1);
        store(A_CTRL, 32'h2);
        check("bad_clr2", 32'(bad_addr), 32'h0);

        store(A_TX, 32'h11);
        store(A_TX, 32'h22);
        for (int k = 0; k < 18; k++) tick();
        check("mid_bit3", 32'(tx), 32'h0);
        check("mid_count", 32'(fifo_count), 32'h1);
        rst_n = 0;
        #1;
        check("mid_rst_tx", 32'(tx), 32'h1);
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        tick();
        rst_n = 1;
        tick();
        store(A_TX, 32'h3C);
        capture("3c", 8'b0011_1100);
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
